// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: steps the NCO frequency word start->stop with per-point dwell (single/repeat/triangle).
// Define NCO_SWEEP_CNT_EN to add the sweep_cnt_o completed-pass counter.
module nco_sweep_ctrl #(
  parameter int FW = 14,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [FW-1:0] cfg_start_i,
  input  logic [FW-1:0] cfg_stop_i,
  input  logic [FW-1:0] cfg_inc_i,
  input  logic [DW-1:0] cfg_dwell_i,
  input  logic [1:0]    cfg_mode_i,
  output logic [FW-1:0] nco_freq_step_o,
  output logic          nco_upd_o,
  input  logic          nco_upd_ack_i,
  output logic          busy_o,
  output logic          done_o
`ifdef NCO_SWEEP_CNT_EN
  ,
  output logic [15:0]   sweep_cnt_o
`endif
);
  typedef enum logic [2:0] {S_IDLE, S_UPD, S_DWELL, S_NEXT, S_DONE} state_t;
  state_t        state;
  logic [FW-1:0] cur, s_start, s_stop, s_inc, nxt_fwd, nxt_rev;
  logic [DW-1:0] s_dwell, cnt;
  logic [1:0]    s_mode;
  logic          dir, at_end;
  // next point toward st, clamped to st on overshoot, carry or borrow
  function automatic logic [FW-1:0] step(input logic [FW-1:0] c, input logic [FW-1:0] i,
                                         input logic [FW-1:0] st, input logic up);
    logic [FW:0] s;
    s = up ? {1'b0, c} + {1'b0, i} : {1'b0, c} - {1'b0, i};
    return up ? ((s >= {1'b0, st}) ? st : s[FW-1:0])
              : ((c < i || s[FW-1:0] <= st) ? st : s[FW-1:0]);
  endfunction
  assign nxt_fwd = step(cur, s_inc, s_stop, dir);
  assign nxt_rev = step(cur, s_inc, s_start, !dir);
  assign at_end = (cur == s_stop) || (s_inc == '0);
  assign nco_freq_step_o = cur;
  assign busy_o = state != S_IDLE;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cur       <= '0;
      s_start   <= '0;
      s_stop    <= '0;
      s_inc     <= '0;
      s_dwell   <= '0;
      s_mode    <= '0;
      cnt       <= '0;
      dir       <= 1'b1;
      nco_upd_o <= 1'b0;
      done_o    <= 1'b0;
`ifdef NCO_SWEEP_CNT_EN
      sweep_cnt_o <= '0;
`endif
    end else if (abort_i) begin
      state     <= S_IDLE;
      nco_upd_o <= 1'b0;
      done_o    <= 1'b0;
    end else if (en_i) begin
      case (state)
        S_IDLE: if (start_i) begin
          s_start   <= cfg_start_i;
          s_stop    <= cfg_stop_i;
          s_inc     <= cfg_inc_i;
          s_dwell   <= cfg_dwell_i;
          s_mode    <= cfg_mode_i;
          cur       <= cfg_start_i;
          dir       <= cfg_stop_i >= cfg_start_i;
          nco_upd_o <= 1'b1;
          state     <= S_UPD;
`ifdef NCO_SWEEP_CNT_EN
          sweep_cnt_o <= '0;
`endif
        end
        S_UPD: if (nco_upd_ack_i) begin
          nco_upd_o <= 1'b0;
          cnt       <= s_dwell;
          state     <= (s_dwell != '0) ? S_DWELL : S_NEXT;
        end
        S_DWELL: begin
          cnt   <= cnt - DW'(1);
          state <= (cnt == DW'(1)) ? S_NEXT : S_DWELL;
        end
        S_NEXT: begin
          if (at_end) begin
`ifdef NCO_SWEEP_CNT_EN
            sweep_cnt_o <= (sweep_cnt_o == 16'hFFFF) ? sweep_cnt_o : sweep_cnt_o + 16'd1;
`endif
            if (s_mode == 2'b01) begin
              cur       <= s_start;
              nco_upd_o <= 1'b1;
              state     <= S_UPD;
            end else if (s_mode == 2'b10) begin
              s_start   <= s_stop;
              s_stop    <= s_start;
              dir       <= !dir;
              cur       <= (s_inc == '0) ? cur : nxt_rev;
              nco_upd_o <= 1'b1;
              state     <= S_UPD;
            end else begin
              done_o <= 1'b1;
              state  <= S_DONE;
            end
          end else begin
            cur       <= nxt_fwd;
            nco_upd_o <= 1'b1;
            state     <= S_UPD;
          end
        end
        S_DONE: begin
          done_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb_nco_sweep_ctrl: directed + randomized sweeps checked against a point-list model of the sweep.
module tb_nco_sweep_ctrl;
  localparam int FW = 14, DW = 16;
  logic clk = 0, reset_n = 0, en_i = 1, start_i = 0, abort_i = 0, nco_upd_ack_i = 1;
  logic [FW-1:0] cfg_start_i = '0, cfg_stop_i = '0, cfg_inc_i = '0, nco_freq_step_o;
  logic [DW-1:0] cfg_dwell_i = '0;
  logic [1:0]    cfg_mode_i = '0;
  logic nco_upd_o, busy_o, done_o;
`ifdef NCO_SWEEP_CNT_EN
  logic [15:0] sweep_cnt;
`endif
  nco_sweep_ctrl #(.FW(FW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n), .en_i(en_i), .start_i(start_i), .abort_i(abort_i),
    .cfg_start_i(cfg_start_i), .cfg_stop_i(cfg_stop_i), .cfg_inc_i(cfg_inc_i),
    .cfg_dwell_i(cfg_dwell_i), .cfg_mode_i(cfg_mode_i), .nco_freq_step_o(nco_freq_step_o),
    .nco_upd_o(nco_upd_o), .nco_upd_ack_i(nco_upd_ack_i), .busy_o(busy_o), .done_o(done_o)
`ifdef NCO_SWEEP_CNT_EN
    , .sweep_cnt_o(sweep_cnt)
`endif
  );
  always #5 clk = ~clk;
  int cyc = 0, n_chk = 0, n_pass = 0, done_cnt = 0, done_cyc = 0, st = 0;
  int got_q[$], gotc_q[$], exp_q[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (reset_n && en_i && !abort_i && nco_upd_o && nco_upd_ack_i) begin
      got_q.push_back(int'(nco_freq_step_o));
      gotc_q.push_back(cyc);
    end
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  function automatic int toward(input int c, input int i, input int b);
    if (c < b) return (c + i >= b) ? b : c + i;
    return (c - i <= b) ? b : c - i;
  endfunction
  // expected issued words: walk toward the current target; at the target apply the mode rule
  function automatic void gen(input int s, input int p, input int i, input int m, input int n);
    int a, b, c, t;
    a = s; b = p; c = s;
    exp_q.delete();
    exp_q.push_back(c);
    while (exp_q.size() < n) begin
      if (c == b || i == 0) begin
        if (m == 1) c = a;
        else if (m == 2) begin
          t = a; a = b; b = t;
          if (i != 0) c = toward(c, i, b);
        end else break;
      end else c = toward(c, i, b);
      exp_q.push_back(c);
    end
  endfunction
  task automatic run_sweep(input int s, input int p, input int i, input int d, input int m,
                           input int npts, input bit disturb);
    int b, want, last;
    bit single;
    single = (m == 0 || m == 3);
    gen(s, p, i, m, single ? 100000 : npts);
    want = exp_q.size();
    got_q.delete(); gotc_q.delete(); done_cnt = 0;
    cfg_start_i = FW'(s); cfg_stop_i = FW'(p); cfg_inc_i = FW'(i);
    cfg_dwell_i = DW'(d); cfg_mode_i = 2'(m);
    nco_upd_ack_i = 1; en_i = 1; start_i = 1; st = cyc;
    tick(1);
    start_i = 0;
    b = 0;
    while ((got_q.size() < want || (single && done_cnt == 0)) && b < 20000) begin
      tick(1);
      b++;
      if (disturb && b == 3) begin
        cfg_start_i = FW'($urandom); cfg_stop_i = FW'($urandom);
        cfg_inc_i = FW'($urandom); cfg_dwell_i = DW'($urandom_range(0, 9));
        cfg_mode_i = 2'($urandom);
        start_i = 1;
        tick(1);
        start_i = 0;
      end
    end
    if (b >= 20000) check("timeout", 0, 1);
    for (int k = 0; k < want && k < got_q.size(); k++) begin
      check($sformatf("word[%0d]", k), got_q[k], exp_q[k]);
      check($sformatf("time[%0d]", k), k == 0 ? gotc_q[0] - st : gotc_q[k] - gotc_q[k-1],
            k == 0 ? 1 : d + 2);
    end
    last = exp_q[want-1];
    if (single) begin
      check("n_upd", got_q.size(), want);
      check("done_time", done_cyc - gotc_q[gotc_q.size()-1], d + 2);
      check("busy_after", int'(busy_o), 0);
      tick(3);
      check("done_once", done_cnt, 1);
    end else begin
      abort_i = 1;
      tick(1);
      abort_i = 0;
      check("abort_upd", int'(nco_upd_o), 0);
      check("abort_busy", int'(busy_o), 0);
      check("abort_freq", int'(nco_freq_step_o), last);
      check("no_done", done_cnt, 0);
    end
  endtask
  initial begin
    int s, p;
    tick(3);
    check("rst_upd", int'(nco_upd_o), 0);
    check("rst_freq", int'(nco_freq_step_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    reset_n = 1;
    tick(2);
    run_sweep(100, 130, 10, 3, 0, 0, 0);
    run_sweep(50, 20, 12, 2, 0, 0, 0);
    run_sweep(0, 4, 2, 0, 2, 9, 0);
    run_sweep(16000, 16383, 300, 1, 0, 0, 0);
    run_sweep(100, 5, 60, 0, 3, 0, 0);
    run_sweep(7, 90, 0, 2, 0, 0, 0);
    run_sweep(33, 33, 5, 1, 1, 4, 0);
    run_sweep(0, 200, 10, 1, 0, 0, 1);
    // ack stall then en_i low inside the dwell
    got_q.delete(); gotc_q.delete(); done_cnt = 0;
    cfg_start_i = 10; cfg_stop_i = 20; cfg_inc_i = 10; cfg_dwell_i = 4; cfg_mode_i = 0;
    nco_upd_ack_i = 0; start_i = 1; st = cyc;
    tick(1);
    start_i = 0;
    for (int k = 0; k < 5; k++) begin
      check("stall_upd", int'(nco_upd_o), 1);
      check("stall_word", int'(nco_freq_step_o), 10);
      tick(1);
    end
    nco_upd_ack_i = 1;
    tick(1);
    en_i = 0;
    tick(3);
    en_i = 1;
    for (int b = 0; b < 40 && done_cnt == 0; b++) tick(1);
    check("stall_n", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("stall_w0", got_q[0], 10);
      check("stall_t0", gotc_q[0] - st, 6);
      check("stall_w1", got_q[1], 20);
      check("stall_gap", gotc_q[1] - gotc_q[0], 9);
    end
    check("stall_done", done_cnt, 1);
    // reset in the middle of a dwell
    cfg_start_i = 500; cfg_stop_i = 900; cfg_inc_i = 50; cfg_dwell_i = 10; cfg_mode_i = 1;
    start_i = 1;
    tick(1);
    start_i = 0;
    tick(4);
    reset_n = 0;
    tick(1);
    check("mrst_upd", int'(nco_upd_o), 0);
    check("mrst_freq", int'(nco_freq_step_o), 0);
    check("mrst_busy", int'(busy_o), 0);
    check("mrst_done", int'(done_o), 0);
    reset_n = 1;
    tick(1);
    for (int r = 0; r < 16; r++) begin
      s = $urandom_range(0, 300);
      p = ($urandom_range(0, 5) == 0) ? s : $urandom_range(0, 300);
      run_sweep(s, p, $urandom_range(1, 40), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(3, 12), 0);
    end
`ifdef NCO_SWEEP_CNT_EN
    got_q.delete(); gotc_q.delete();
    cfg_start_i = 0; cfg_stop_i = 2; cfg_inc_i = 1; cfg_dwell_i = 1; cfg_mode_i = 1;
    start_i = 1;
    tick(1);
    start_i = 0;
    for (int b = 0; b < 200 && got_q.size() < 9; b++) tick(1);
    tick(2);
    check("sweep_cnt", int'(sweep_cnt), 3);
    abort_i = 1;
    tick(1);
    abort_i = 0;
    start_i = 1;
    tick(1);
    start_i = 0;
    check("sweep_cnt_clr", int'(sweep_cnt), 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/nco_sweep_ctrl.md
Name: nco_sweep_ctrl

Overview:
- Sequences the NCO frequency word for linear frequency sweeps in the waveform generator.
- Steps the NCO frequency step word from a start value to a stop value in fixed increments, and holds each point for a programmable dwell time.
- Supports single, repeat and triangle sweep modes.
- Sits between the main control FSM (config and start) and the NCO frequency-step input (valid/ack update handshake).

Parameters:
FW, 14, width of NCO frequency step word
DW, 16, width of dwell counter / dwell config

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous active-low reset
en_i  input  1  global enable; low freezes all state except abort
start_i  input  1  one-cycle pulse, starts sweep (accepted only in S_IDLE with en_i high)
abort_i  input  1  level/pulse, terminates sweep
cfg_start_i  input  FW  first frequency word
cfg_stop_i  input  FW  last frequency word
cfg_inc_i  input  FW  step magnitude
cfg_dwell_i  input  DW  cycles to hold each point after ack
cfg_mode_i  input  2  00 single, 01 repeat, 10 triangle, 11 treated as single
nco_freq_step_o  output  FW  frequency word to NCO
nco_upd_o  output  1  update valid to NCO
nco_upd_ack_i  input  1  NCO accepts update
busy_o  output  1  high in any state except S_IDLE
done_o  output  1  one-cycle pulse at single-sweep completion

Behaviour:
- Interface: one clock `clk`; reset `reset_n` is synchronous, active-low.
- Reset values: all outputs 0, state S_IDLE, shadow config 0, dwell counter 0, direction = up.
- States: S_IDLE, S_UPD, S_DWELL, S_NEXT, S_DONE.
- S_IDLE: on start_i with en_i high:
  - latch all cfg_* into shadow registers; cfg changes mid-sweep are ignored.
  - cur = cfg_start_i; dir = up if cfg_stop_i >= cfg_start_i, else down.
  - go to S_UPD.
- S_UPD:
  - nco_upd_o = 1; nco_freq_step_o = cur, stable until ack.
  - Transfer occurs in a cycle where nco_upd_o and nco_upd_ack_i are both high.
  - On transfer: dwell counter = dwell; go to S_DWELL if dwell != 0, else S_NEXT.
  - nco_upd_o drops the cycle after the transfer.
- S_DWELL: decrement counter each en_i-high cycle; on counter reaching 1, go to S_NEXT. Dwell D therefore gives exactly D cycles in S_DWELL.
- S_NEXT computes the next point in FW+1 bits:
  - up: nxt = cur + inc; if nxt >= stop or carry, nxt = stop.
  - down: if cur < inc or cur - inc <= stop, nxt = stop.
  - If cur == stop (endpoint already issued):
    - single: go to S_DONE.
    - repeat: cur = start, go to S_UPD.
    - triangle: swap the roles of start and stop, invert dir, then compute the next point from cur.
  - Otherwise cur = nxt, go to S_UPD.
- S_DONE: done_o = 1 for one cycle, go to S_IDLE.
- Degenerate configs:
  - inc == 0 or start == stop: one point is issued, then the mode rule applies at the endpoint.
  - Repeat/triangle with start == stop reissues the same word every dwell.
- Latency: start_i in cycle N gives nco_upd_o high in cycle N+1, with freq = cfg_start_i.
- en_i low: state, counters and outputs hold; nco_upd_o stays asserted if already in S_UPD; ack is ignored while en_i is low.
- abort_i high (any en_i): next state S_IDLE.
  - nco_upd_o = 0 next cycle; no done_o.
  - nco_freq_step_o keeps its last value.
  - If abort and ack coincide, abort wins; the acked word remains on nco_freq_step_o.
- start_i outside S_IDLE is ignored.
- Reset mid-sweep returns everything to reset values next edge.

Optional Feature:
- Macro: NCO_SWEEP_CNT_EN.
- Defined:
  - adds output sweep_cnt_o[15:0], counting completed passes (each arrival at the endpoint after its dwell).
  - cleared to 0 on accepted start_i and reset; saturates at 0xFFFF.
- Undefined: port absent, no counter logic.

Test Plan:
- Single up: start=100, stop=130, inc=10, dwell=3, ack tied high.
  - Expected: updates 100, 110, 120, 130, each separated by 1 upd + 3 dwell + 1 next cycles.
  - done_o pulses once; busy_o low after.
- Overshoot clamp and down sweep: start=50, stop=20, inc=12 → updates 50, 38, 26, 20, then done.
- Triangle: start=0, stop=4, inc=2, dwell=0 → 0, 2, 4, 2, 0, 2, 4, …; no done_o; abort mid-sweep → nco_upd_o low next cycle, freq holds.
- Handshake stall: ack held low 5 cycles in S_UPD → nco_upd_o and the word stay stable; transfer on the first ack; en_i low for 3 dwell cycles extends the dwell by 3.
- Edge cases:
  - inc=0 in single mode → exactly one update, then done.
  - start_i while busy → ignored.
  - cfg change mid-sweep → no effect.
  - reset_n low mid-S_DWELL → all outputs 0 next edge.
- With NCO_SWEEP_CNT_EN: repeat start=0, stop=2, inc=1 for 3 passes → sweep_cnt_o = 3; new start_i clears it.
